// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared backend types for dispatch (ROB/dispatch-queue payloads, FSM states)
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif

package dispatch_pkg;

    localparam int DQ_INT    = 0;
    localparam int DQ_MEM    = 1;
    localparam int ROB_IDX_W = 6;

    typedef logic [ROB_IDX_W-1:0] robIdx_t;

    typedef struct packed {
        logic [15:0] instmeta;
        logic [0:0]  dispQue_id;
        logic        need_serialize;
    } renameInfo_t;

    typedef struct packed {
        renameInfo_t info;
        robIdx_t     rob_idx;
    } dispInfo_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN_PRE,
        DRAIN_POST
    } dispState_e;

endpackage

// File: rtl/dispatch_compact.sv
// rtl/dispatch_compact.sv - prefix-sum packer: moves selected slots to ports 0..n-1 in order
module dispatch_compact
    import dispatch_pkg::*;
#(
    parameter int WIDTH = `RENAME_WIDTH
) (
    input  logic      [WIDTH-1:0] i_sel,
    input  dispInfo_t [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_vld,
    output dispInfo_t [WIDTH-1:0] o_data
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] prefix [WIDTH];
    logic [CW-1:0] total;

    always_comb begin
        total = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prefix[i] = total;
            total     = total + CW'(i_sel[i]);
        end
    end

    // Output port j takes the selected slot whose prefix count equals j.
    always_comb begin
        o_vld  = '0;
        o_data = '0;
        for (int j = 0; j < WIDTH; j++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i_sel[i] && (prefix[i] == CW'(j))) begin
                    o_vld[j]  = 1'b1;
                    o_data[j] = i_data[i];
                end
            end
        end
    end

endmodule

// File: rtl/dispatch.sv
// rtl/dispatch.sv - ROB allocation and dispatch-queue routing with serialize drain; optional DISPATCH_DIFFTEST_EN
module dispatch
    import dispatch_pkg::*;
#(
    parameter int WIDTH  = `RENAME_WIDTH,
    parameter int NUM_DQ = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_squash_vld,
    output logic                                          o_stall,
    input  logic        [WIDTH-1:0]                       i_rename_vld,
    input  renameInfo_t [WIDTH-1:0]                       i_renameInfo,
    input  logic        [$clog2(WIDTH+1)-1:0]             i_rob_free,
    input  logic                                          i_rob_empty,
    input  robIdx_t     [WIDTH-1:0]                       i_rob_enq_idx,
    output logic        [WIDTH-1:0]                       o_rob_enq_vld,
    output renameInfo_t [WIDTH-1:0]                       o_rob_enq_info,
    input  logic        [NUM_DQ-1:0][$clog2(WIDTH+1)-1:0] i_dq_free,
    output logic        [NUM_DQ-1:0][WIDTH-1:0]           o_dq_enq_vld,
    output dispInfo_t   [NUM_DQ-1:0][WIDTH-1:0]           o_dq_enq_info
);

    dispState_e       state, state_nxt;
    logic [WIDTH-1:0] done_mask, done_nxt;
    logic [WIDTH-1:0] eff, k_onehot, below_k, cand, fired;
    logic             has_k, drained, fire;
    int               rob_need;
    int               dq_need [NUM_DQ];

    always_comb begin
        eff      = i_rename_vld & ~done_mask;
        has_k    = 1'b0;
        k_onehot = '0;
        // Scan downward so the lowest serializing slot wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (eff[i] && i_renameInfo[i].need_serialize) begin
                has_k       = 1'b1;
                k_onehot    = '0;
                k_onehot[i] = 1'b1;
            end
        end
        below_k = has_k ? (eff & (k_onehot - WIDTH'(1))) : '0;
        drained = i_rob_empty && !(|o_rob_enq_vld) && !(|o_dq_enq_vld);

        cand      = '0;
        state_nxt = state;
        case (state)
            RUN: begin
                if (!has_k)
                    cand = eff;
                else if (|below_k)
                    cand = below_k;
                else
                    state_nxt = DRAIN_PRE;
            end
            DRAIN_PRE: begin
                if (drained)
                    cand = k_onehot;
            end
            DRAIN_POST: begin
                if (drained)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase

        rob_need = 0;
        for (int i = 0; i < WIDTH; i++)
            rob_need = rob_need + int'(cand[i]);
        fire = (|cand) && (rob_need <= int'(i_rob_free)) && !i_squash_vld;
        for (int q = 0; q < NUM_DQ; q++) begin
            dq_need[q] = 0;
            for (int i = 0; i < WIDTH; i++)
                if (cand[i] && (int'(i_renameInfo[i].dispQue_id) == q))
                    dq_need[q] = dq_need[q] + 1;
            if (dq_need[q] > int'(i_dq_free[q]))
                fire = 1'b0;
        end

        fired   = fire ? cand : '0;
        o_stall = !i_squash_vld && (|(eff & ~fired));

        if (state == DRAIN_PRE && fire)
            state_nxt = DRAIN_POST;

        if (i_squash_vld) begin
            state_nxt = RUN;
            done_nxt  = '0;
        end else if (fire) begin
            done_nxt = (|(eff & ~fired)) ? (done_mask | fired) : '0;
        end else begin
            done_nxt = done_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            done_mask <= '0;
        end else begin
            state     <= state_nxt;
            done_mask <= done_nxt;
        end
    end

    dispInfo_t [WIDTH-1:0]             slot_data, rob_pk, rob_tagged;
    logic      [WIDTH-1:0]             rob_pk_vld;
    renameInfo_t [WIDTH-1:0]           rob_info;
    logic      [NUM_DQ-1:0][WIDTH-1:0] dq_sel, dq_pk_vld;
    dispInfo_t [NUM_DQ-1:0][WIDTH-1:0] dq_pk;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            slot_data[i].info    = i_renameInfo[i];
            slot_data[i].rob_idx = '0;
        end
    end

    dispatch_compact #(.WIDTH(WIDTH)) u_rob_pack (
        .i_sel  (fired),
        .i_data (slot_data),
        .o_vld  (rob_pk_vld),
        .o_data (rob_pk)
    );

    // Queues pack from the ROB-ordered list so each entry inherits its ROB port's index.
    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            rob_tagged[j]         = rob_pk[j];
            rob_tagged[j].rob_idx = i_rob_enq_idx[j];
            rob_info[j]           = rob_pk[j].info;
        end
        for (int q = 0; q < NUM_DQ; q++)
            for (int j = 0; j < WIDTH; j++)
                dq_sel[q][j] = rob_pk_vld[j] && (int'(rob_pk[j].info.dispQue_id) == q);
    end

    for (genvar g = 0; g < NUM_DQ; g++) begin : g_dq_pack
        dispatch_compact #(.WIDTH(WIDTH)) u_dq_pack (
            .i_sel  (dq_sel[g]),
            .i_data (rob_tagged),
            .o_vld  (dq_pk_vld[g]),
            .o_data (dq_pk[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || i_squash_vld) begin
            o_rob_enq_vld <= '0;
            o_dq_enq_vld  <= '0;
        end else begin
            o_rob_enq_vld <= rob_pk_vld;
            o_dq_enq_vld  <= dq_pk_vld;
        end
        o_rob_enq_info <= rob_info;
        o_dq_enq_info  <= dq_pk;
    end

`ifdef DISPATCH_DIFFTEST_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++)
                if (fired[i])
                    update_instPos(i_renameInfo[i].instmeta, difftest_def::AT_dispatch);
        end
    end
`endif

endmodule

// File: doc/dispatch.md
# dispatch

Takes the renamed instruction group from rename, allocates ROB entries, and routes each instruction to its dispatch queue (`dispQue_id`). A group is held upstream via `o_stall` until every slot in it has been sent. Serializing instructions (`need_serialize`) are sent alone, with the ROB drained both before and after them. Sits between rename and the dispatch queues / ROB.

## Interface
- `WIDTH`, default `` `RENAME_WIDTH ``: instruction slots per cycle.
- `NUM_DQ`, default 2: number of dispatch queues (0 = int, 1 = mem).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_squash_vld`  in  1  pipeline flush.
- `o_stall`  out  1  to rename `i_stall`; rename holds its output registers while this is high.
- `i_rename_vld`  in  WIDTH  valid slots from rename.
- `i_renameInfo`  in  renameInfo_t[WIDTH]  renamed instructions.
- `i_rob_free`  in  `$clog2(WIDTH+1)`  free ROB entries, saturated at WIDTH.
- `i_rob_empty`  in  1  ROB holds no instructions.
- `i_rob_enq_idx`  in  robIdx_t[WIDTH]  ROB index for packed enqueue port j.
- `o_rob_enq_vld`  out  WIDTH  packed ROB enqueue valids.
- `o_rob_enq_info`  out  renameInfo_t[WIDTH]  packed ROB enqueue payload.
- `i_dq_free`  in  `$clog2(WIDTH+1)`[NUM_DQ]  free entries per queue, saturated at WIDTH.
- `o_dq_enq_vld`  out  WIDTH[NUM_DQ]  per-queue packed enqueue valids.
- `o_dq_enq_info`  out  dispInfo_t[NUM_DQ][WIDTH]  renameInfo_t plus rob_idx.

## Operation
- **Pending slots.** `eff = i_rename_vld & ~done_mask`. `done_mask` marks slots already sent from the currently held group.
- **Serialize slot.** k = lowest slot in `eff` with `need_serialize`.
- **Candidate set C.**
  - RUN, no k: all of `eff`.
  - RUN, k above the lowest `eff` slot: `eff` slots below k.
  - DRAIN_PRE, once `i_rob_empty && !any output reg valid`: slot k only.
  - Otherwise: empty.
- **Fire condition.** Fire when C is non-empty, `popcount(C) <= i_rob_free`, and for each queue q, `count(C` routed to q`) <= i_dq_free[q]`. Counts are zero-extended before comparing.
- **All-or-nothing.** C fires completely or not at all. There is no partial issue of C.
- **Packing.** Fired slots are packed in program order onto ROB ports 0..n-1. Port j carries `rob_idx = i_rob_enq_idx[j]`. Each queue gets its own packed list, in order, with the matching rob_idx.
- **Stall.** `o_stall = |(eff & ~fired)`. On a full fire, `done_mask` clears to 0. On a partial fire, `done_mask |= fired`.
- **FSM: RUN.**
  - If k is the lowest `eff` slot, go to DRAIN_PRE (nothing fires this cycle).
- **FSM: DRAIN_PRE.**
  - Wait for drain (`i_rob_empty && !any output reg valid`).
  - Then fire k alone and go to DRAIN_POST. If resources are short, stay in DRAIN_PRE.
- **FSM: DRAIN_POST.**
  - Nothing fires.
  - When `i_rob_empty && !any output reg valid`, go to RUN.
- **Squash.**
  - Suppresses fire in the squash cycle and forces `o_stall = 0`.
  - Clears `done_mask`, all output valids, and sets state to RUN.
  - Squash has priority over every other event.
- **Reset.** State RUN, `done_mask = 0`, all output valids 0, `o_stall = 0`. The payload registers are not reset.

## Timing
- `o_stall` is combinational from the inputs and state in the same cycle.
- Fire in cycle t puts the valids and payload on the enqueue outputs in cycle t+1, for exactly one cycle. Output valids are 0 in any cycle following a no-fire cycle.
- No valid input: `o_stall = 0`, no state change except DRAIN_POST exit.
- Serialize at slot 0 in RUN with ROB empty: DRAIN_PRE is entered at t, k fires at t+1 at the earliest.
- `i_rob_free = 0` or a full queue: `o_stall = 1` and the group is held indefinitely; there is no timeout.
- Two serialize slots in one group: each is handled by its own DRAIN_PRE/DRAIN_POST pass, in order.

## Configuration
- `DISPATCH_DIFFTEST_EN`
  - Defined: for each fired slot, call `update_instPos(instmeta, difftest_def::AT_dispatch)` in the firing cycle.
  - Undefined: no DPI calls are compiled; the logic is otherwise identical.

## Structure
- **Shared backend package:**
  - `dispInfo_t` (renameInfo_t + robIdx_t).
  - `dispState_e {RUN, DRAIN_PRE, DRAIN_POST}`.
  - `DQ_INT = 0`, `DQ_MEM = 1`.
- **Sub-module `dispatch_compact`:** WIDTH-way prefix-sum packer taking a select mask and payload, producing packed valid/payload. It is instantiated once for the ROB and once per queue.

## Test plan
- 4 int ALU ops, `i_rob_free=4`, `i_dq_free[0]=4` → `o_stall=0`; next cycle `o_rob_enq_vld=4'b1111`, rob_idx = `i_rob_enq_idx[0..3]`.
- Slots {int, mem, int, mem}, `i_dq_free[1]=1` → `o_stall=1`, no enqueue; set free=2 → all 4 fire, DQ0 and DQ1 each packed on ports 0,1.
- Serialize at slot 2, ROB non-empty → slots 0–1 fire, `o_stall` stays 1; `i_rob_empty=1` → slot 2 alone on port 0; ROB empty again → slot 3 fires, `o_stall=0`.
- `i_rob_free=3` with 4 valid → stall, no partial fire; raise to 4 → all fire in the same cycle.
- Squash in DRAIN_PRE with `done_mask=4'b0011` → next cycle state RUN, `done_mask=0`, all output valids 0.
- `rst` mid-DRAIN_POST with output regs valid → next cycle all valids 0, `o_stall=0`, state RUN.
